// File: rtl/segment_scan_decoder.sv
// Display-bus monitor: samples a scanned six-digit seven-segment bus,
// rebuilds HH:MM:SS frames, range-checks them and publishes good ones.
module segment_scan_decoder #(
  parameter int unsigned SETTLE         = 4,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter bit          EN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] DigitEnable,
  input  logic [6:0] DigitValue,
  output logic [3:0] HourMSD,
  output logic [3:0] HourLSD,
  output logic [3:0] MinMSD,
  output logic [3:0] MinLSD,
  output logic [3:0] SecMSD,
  output logic [3:0] SecLSD,
  output logic       FrameValid,
  output logic       FrameError,
  output logic       Present
);

  localparam logic [5:0] EN_IDLE  = EN_ACTIVE_LOW  ? 6'h3F : 6'h00;
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [5:0]      en_s1_q, en_s2_q, en_prev_q;
  logic [6:0]      seg_s1_q, seg_s2_q, seg_prev_q;
  logic [3:0]      cnt_q, cnt_d;
  logic            capd_q, capd_d;
  logic [5:0]      seen_q, seen_d;
  logic            err_q, err_d;
  logic            cmp_q;
  logic [5:0][3:0] stg_q;
  logic [5:0][3:0] out_q;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic            pres_q, fv_q, fe_q;

  logic [5:0] en_n;
  logic [6:0] seg_n;
  logic       one, same, cap, sat, clr, ok, bad;
  logic [2:0] idx;
  logic [3:0] dec;
  logic [5:0] capbit;

  assign en_n  = en_s2_q ^ {6{EN_ACTIVE_LOW}};
  assign seg_n = seg_s2_q ^ {7{SEG_ACTIVE_LOW}};
  assign one   = (en_n != 6'd0) && ((en_n & (en_n - 6'd1)) == 6'd0);
  assign same  = (en_n == en_prev_q) && (seg_n == seg_prev_q);
  assign sat   = &to_q;
  assign clr   = cmp_q || sat;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 6; i++)
      if (en_n[i]) idx = 3'(i);
  end

  always_comb begin
    dec = 4'd0;
    bad = 1'b0;
    case (seg_n)
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d = 4'd0;
    if (one && same)
      cnt_d = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + 4'd1;
  end

  // One capture per steady digit; the flag rearms on any change.
  assign cap    = one && same && (cnt_d == SETTLE_C) && !capd_q;
  assign capd_d = (one && same) && (capd_q || cap);
  assign capbit = cap ? (6'd1 << idx) : 6'd0;

  // A capture coinciding with completion or timeout starts a new frame.
  assign seen_d = (clr ? 6'd0 : seen_q) | capbit;
  assign err_d  = (clr ? 1'b0 : err_q) | (cap & bad);
  assign to_d   = cap ? '0 : (sat ? to_q : to_q + 1'b1);

  assign ok = !err_q && (stg_q[5] <= 4'd2) &&
              ((stg_q[5] != 4'd2) || (stg_q[4] <= 4'd3)) &&
              (stg_q[3] <= 4'd5) && (stg_q[1] <= 4'd5);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_s1_q    <= EN_IDLE;
      en_s2_q    <= EN_IDLE;
      seg_s1_q   <= SEG_IDLE;
      seg_s2_q   <= SEG_IDLE;
      en_prev_q  <= 6'd0;
      seg_prev_q <= 7'd0;
      cnt_q      <= 4'd0;
      capd_q     <= 1'b0;
      seen_q     <= 6'd0;
      err_q      <= 1'b0;
      cmp_q      <= 1'b0;
      stg_q      <= '0;
      out_q      <= '0;
      to_q       <= '0;
      pres_q     <= 1'b0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      en_s1_q    <= DigitEnable;
      en_s2_q    <= en_s1_q;
      seg_s1_q   <= DigitValue;
      seg_s2_q   <= seg_s1_q;
      en_prev_q  <= en_n;
      seg_prev_q <= seg_n;
      cnt_q      <= cnt_d;
      capd_q     <= capd_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      cmp_q      <= cap && (seen_d == 6'h3F);
      to_q       <= to_d;
      pres_q     <= cap ? 1'b1 : (sat ? 1'b0 : pres_q);
      fv_q       <= cmp_q && ok;
      fe_q       <= cmp_q && !ok;
      if (cap) stg_q[idx] <= dec;
      if (cmp_q && ok) out_q <= stg_q;
    end
  end

  assign HourMSD    = out_q[5];
  assign HourLSD    = out_q[4];
  assign MinMSD     = out_q[3];
  assign MinLSD     = out_q[2];
  assign SecMSD     = out_q[1];
  assign SecLSD     = out_q[0];
  assign FrameValid = fv_q;
  assign FrameError = fe_q;
  assign Present    = pres_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Bench for segment_scan_decoder: scan vectors with a pulse scoreboard,
// plus short-hold, timeout and mid-scan reset sequences.
module tb_segment_scan_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] DigitEnable;
  logic [6:0] DigitValue;
  logic [3:0] HourMSD, HourLSD, MinMSD, MinLSD, SecMSD, SecLSD;
  logic       FrameValid, FrameError, Present;

  segment_scan_decoder dut (
    .CLK(CLK), .RST(RST),
    .DigitEnable(DigitEnable), .DigitValue(DigitValue),
    .HourMSD(HourMSD), .HourLSD(HourLSD),
    .MinMSD(MinMSD), .MinLSD(MinLSD),
    .SecMSD(SecMSD), .SecLSD(SecLSD),
    .FrameValid(FrameValid), .FrameError(FrameError),
    .Present(Present)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    bit          ok;
    logic [23:0] out;
  } exp_t;

  typedef struct {
    logic [23:0] bcd;
    logic [6:0]  bad;
    int          hold;
    bit          glitch;
    bit          ok;
    logic [23:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [23:0] outs();
    return {HourMSD, HourLSD, MinMSD, MinLSD, SecMSD, SecLSD};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (FrameValid === 1'b1 || FrameError === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got FV=%b FE=%b out=%h expected none",
                 FrameValid, FrameError, outs());
      end else begin
        e = sb.pop_front();
        chk("pulse_valid", 32'(FrameValid), 32'(e.ok));
        chk("pulse_error", 32'(FrameError), 32'(!e.ok));
        chk("pulse_out", 32'(outs()), 32'(e.out));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic blank(input int n);
    DigitEnable = 6'h3F;
    DigitValue  = 7'h7F;
    repeat (n) tick();
  endtask

  task automatic drive_digit(input int d, input logic [6:0] pat,
                             input int hold);
    DigitEnable = ~(6'd1 << d);
    DigitValue  = ~pat;
    repeat (hold) tick();
  endtask

  task automatic scan(input logic [23:0] bcd, input logic [6:0] bad,
                      input int hold, input bit glitch,
                      input logic [5:0] mask);
    logic [6:0] pat;
    for (int d = 5; d >= 0; d--) begin
      if (mask[d]) begin
        pat = SEG[bcd[d*4 +: 4]];
        if (d == 0 && bad != 7'd0) pat = bad;
        drive_digit(d, pat, hold);
        if (glitch) begin
          DigitEnable = ~6'b000011;
          tick();
          blank(1);
        end else begin
          blank(2);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{24'h235958, 7'h00, 8, 1'b0, 1'b1, 24'h235958};
    vecs[1] = '{24'h235958, 7'h00, 8, 1'b0, 1'b1, 24'h235958};
    vecs[2] = '{24'h235958, 7'h49, 8, 1'b0, 1'b0, 24'h235958};
    vecs[3] = '{24'h000001, 7'h00, 8, 1'b0, 1'b1, 24'h000001};
    vecs[4] = '{24'h240000, 7'h00, 8, 1'b0, 1'b0, 24'h000001};
    vecs[5] = '{24'h126000, 7'h00, 8, 1'b0, 1'b0, 24'h000001};
    vecs[6] = '{24'h194537, 7'h00, 8, 1'b1, 1'b1, 24'h194537};
    vecs[7] = '{24'h084712, 7'h00, 5, 1'b0, 1'b1, 24'h084712};

    RST = 1'b0;
    DigitEnable = 6'h3F;
    DigitValue  = 7'h7F;
    repeat (3) tick();
    chk("reset_out", 32'(outs()), 32'h0);
    chk("reset_present", 32'(Present), 32'h0);
    chk("reset_pulses", 32'({FrameValid, FrameError}), 32'h0);
    RST = 1'b1;
    blank(4);

    for (int i = 0; i < 8; i++) begin
      sb.push_back('{ok: vecs[i].ok, out: vecs[i].exp});
      scan(vecs[i].bcd, vecs[i].bad, vecs[i].hold, vecs[i].glitch, 6'h3F);
      repeat (10) tick();
      chk($sformatf("vec%0d_drained", i), 32'(sb.size()), 32'h0);
      chk($sformatf("vec%0d_out", i), 32'(outs()), 32'(vecs[i].exp));
      if (i == 0) chk("present_up", 32'(Present), 32'h1);
    end

    // SecLSD held 3 cycles: not captured, frame stays open
    scan(24'h135207, 7'h00, 8, 1'b0, 6'b111110);
    drive_digit(0, SEG[7], 3);
    blank(2);
    repeat (10) tick();
    chk("short_hold_out", 32'(outs()), 32'h084712);
    sb.push_back('{ok: 1'b1, out: 24'h135207});
    drive_digit(0, SEG[7], 8);
    blank(2);
    repeat (10) tick();
    chk("short_fix_drained", 32'(sb.size()), 32'h0);
    chk("short_fix_out", 32'(outs()), 32'h135207);

    // Loss of signal after a partial frame
    scan(24'h112233, 7'h00, 8, 1'b0, 6'b111000);
    repeat (60000) tick();
    chk("present_held", 32'(Present), 32'h1);
    repeat (6000) tick();
    chk("present_lost", 32'(Present), 32'h0);
    chk("timeout_out_hold", 32'(outs()), 32'h135207);
    drive_digit(2, SEG[2], 8);
    chk("present_back", 32'(Present), 32'h1);
    blank(2);
    scan(24'h112233, 7'h00, 8, 1'b0, 6'b000011);
    repeat (10) tick();
    chk("partial_dropped_out", 32'(outs()), 32'h135207);
    sb.push_back('{ok: 1'b1, out: 24'h112233});
    scan(24'h112233, 7'h00, 8, 1'b0, 6'h3F);
    repeat (10) tick();
    chk("restart_drained", 32'(sb.size()), 32'h0);
    chk("restart_out", 32'(outs()), 32'h112233);

    // Reset mid-scan
    scan(24'h112233, 7'h00, 8, 1'b0, 6'b110000);
    drive_digit(3, SEG[2], 3);
    RST = 1'b0;
    #1;
    chk("rst_out", 32'(outs()), 32'h0);
    chk("rst_present", 32'(Present), 32'h0);
    blank(3);
    #2;
    RST = 1'b1;
    blank(3);
    scan(24'h112233, 7'h00, 8, 1'b0, 6'b001000);
    repeat (10) tick();
    chk("post_rst_out", 32'(outs()), 32'h0);
    chk("post_rst_present", 32'(Present), 32'h1);

    chk("final_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
